lsu_mem_bridge: RTL

Downstream neighbour of the load/store/atomic execution unit. Converts that unit's two-phase drive/free bundled-data requests into accesses on a clocked single-port data SRAM. Returns load data and atomic old-values on the oprand return channel, accepts the atomic's computed result, and writes it back.
Implements sub-word store byte-enables, load extension and misalignment trapping.

---
 rtl/lsu_mem_bridge_pkg.sv | 98 +++++++++
 rtl/lsu_mem_bridge_toggle_sync.sv | 40 ++++
 rtl/lsu_mem_bridge.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_bridge_pkg
//  Description : Shared definitions for the LSU-to-SRAM bridge:
//                - request type-field bit positions
//                - access size encodings
//                - bridge FSM state enum
//                - reset constants
//                - lane helper functions (misalignment, byte enables,
//                  store lane replication, load extraction/extension)
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_mem_bridge_pkg;

    // Bit positions inside the 6-bit request type field
    localparam int c_TYPE_STORE    = 5;
    localparam int c_TYPE_ATOMIC   = 4;
    localparam int c_TYPE_UNSIGNED = 3;

    // Access size encodings (type[1:0])
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;    // illegal size

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHK   = 3'd1,
        ST_RREQ  = 3'd2,
        ST_RDATA = 3'd3,
        ST_RET   = 3'd4,
        ST_AWAIT = 3'd5,
        ST_WREQ  = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    localparam state_t      c_RESET_STATE = ST_IDLE;
    localparam logic [31:0] c_RESET_WORD  = 32'h0000_0000;
    localparam logic [3:0]  c_RESET_BE    = 4'b0000;
    localparam logic [3:0]  c_BE_ALL      = 4'b1111;

    // Illegal size, halfword on an odd byte, word off a word boundary,
    // or any atomic that is not a full word.
    function automatic logic isMisaligned(input logic [1:0] size,
                                          input logic       atomic,
                                          input logic [1:0] addrLo);
        logic mis;
        mis = 1'b0;
        if (size == SZ_X)                          mis = 1'b1;
        if ((size == SZ_H) && addrLo[0])           mis = 1'b1;
        if ((size == SZ_W) && (addrLo != 2'b00))   mis = 1'b1;
        if (atomic && (size != SZ_W))              mis = 1'b1;
        return mis;
    endfunction

    function automatic logic [3:0] storeBe(input logic [1:0] size,
                                           input logic [1:0] addrLo);
        logic [3:0] be;
        case (size)
            SZ_B:    be = 4'b0001 << addrLo;
            SZ_H:    be = 4'b0011 << addrLo;
            default: be = c_BE_ALL;
        endcase
        return be;
    endfunction

    // Right-aligned store data is replicated across every lane so the
    // byte enables alone choose where it lands.
    function automatic logic [31:0] storeLanes(input logic [1:0]  size,
                                               input logic [31:0] data);
        logic [31:0] lanes;
        case (size)
            SZ_B:    lanes = {4{data[7:0]}};
            SZ_H:    lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] loadExtract(input logic [31:0] word,
                                                input logic [1:0]  addrLo,
                                                input logic [1:0]  size,
                                                input logic        isUnsigned);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {addrLo, 3'b000};
        case (size)
            SZ_B:    result = isUnsigned ? {24'h000000, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    result = isUnsigned ? {16'h0000, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            default: result = shifted;
        endcase
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_bridge_toggle_sync.sv
`default_nettype none
// ============================================================================
//  Module      : toggle_sync
//  Description : SYNC_STAGES-deep flip-flop synchronizer for a two-phase
//                (toggle) signal crossing into the clk domain.
//  Ports       : clk      - destination clock
//                rstn     - asynchronous active-low reset (clears chain)
//                i_toggle - asynchronous toggle input
//                o_toggle - synchronized toggle
//  Revision    : 1.0 - initial release
// ============================================================================
module toggle_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_toggle,
    output logic o_toggle
);

    generate
        if (SYNC_STAGES <= 1) begin : g_single
            logic r_stage;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) r_stage <= 1'b0;
                else       r_stage <= i_toggle;
            end
            assign o_toggle = r_stage;
        end else begin : g_chain
            logic [SYNC_STAGES-1:0] r_stages;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) r_stages <= '0;
                else       r_stages <= {r_stages[SYNC_STAGES-2:0], i_toggle};
            end
            assign o_toggle = r_stages[SYNC_STAGES-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/lsu_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_bridge
//  Description : Converts two-phase bundled-data load/store/atomic requests
//                from the LSA into single-port SRAM accesses. Returns load
//                data / atomic old values, accepts the atomic result and
//                writes it back. Handles sub-word byte enables, load
//                extension and misalignment trapping.
//  Ports       : clk, rstn (async, active-low)
//                Request   : i_driveFromLSA / o_freeToLSA toggles with
//                            i_addr, i_index, i_type, i_storedata, i_areg
//                Return    : o_driveToLSA / i_freeFromLSA toggles with
//                            o_oprandToLSA, o_indexToLSA, o_aregToLSA
//                Atomic    : i_driveFromLSAForA / o_freeToLSAForA toggles
//                            with i_resultFromLSA
//                SRAM      : o_mem_req/we/be/addr/wdata, i_mem_ready,
//                            i_mem_rdata (1 cycle after accepted read)
//                Status    : o_err_misalign (1-cycle pulse)
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_bridge #(
    parameter int SYNC_STAGES = 2,
    parameter int MEM_AW      = 30
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_driveFromLSA,
    output logic              o_freeToLSA,
    input  logic [31:0]       i_addr,
    input  logic [3:0]        i_index,
    input  logic [5:0]        i_type,
    input  logic [31:0]       i_storedata,
    input  logic [4:0]        i_areg,
    output logic              o_driveToLSA,
    input  logic              i_freeFromLSA,
    output logic [31:0]       o_oprandToLSA,
    output logic [3:0]        o_indexToLSA,
    output logic [4:0]        o_aregToLSA,
    input  logic              i_driveFromLSAForA,
    output logic              o_freeToLSAForA,
    input  logic [31:0]       i_resultFromLSA,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [3:0]        o_mem_be,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_ready,
    input  logic [31:0]       i_mem_rdata,
    output logic              o_err_misalign
);

    import lsu_mem_bridge_pkg::*;

    // ---------------------------------------------------------------- sync
    logic w_reqSync;
    logic w_resSync;
    logic w_ackSync;

    toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_syncReq (
        .clk      (clk),
        .rstn     (rstn),
        .i_toggle (i_driveFromLSA),
        .o_toggle (w_reqSync)
    );

    toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_syncRes (
        .clk      (clk),
        .rstn     (rstn),
        .i_toggle (i_driveFromLSAForA),
        .o_toggle (w_resSync)
    );

    toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_syncAck (
        .clk      (clk),
        .rstn     (rstn),
        .i_toggle (i_freeFromLSA),
        .o_toggle (w_ackSync)
    );

    // ------------------------------------------------------------ registers
    state_t            r_state;
    state_t            w_stateNext;

    logic [31:0]       r_addr;
    logic [3:0]        r_index;
    logic              r_isStore;
    logic              r_isAtomic;
    logic              r_isUnsigned;
    logic [1:0]        r_size;
    logic [31:0]       r_storedata;
    logic [4:0]        r_areg;
    logic              r_faulted;       // current transaction trapped in CHK

    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [31:0]       r_oprand;
    logic [3:0]        r_indexRet;
    logic [4:0]        r_aregRet;

    logic              r_freeToLSA;
    logic              r_driveToLSA;
    logic              r_freeToLSAForA;
    logic              r_errMisalign;

    // Reserved type bit carries no meaning here.
    logic              w_unused;
    assign w_unused = i_type[2];

    logic w_reqPending;
    logic w_resPending;
    logic w_retAcked;
    logic w_misaligned;

    assign w_reqPending = (w_reqSync != r_freeToLSA);
    assign w_resPending = (w_resSync != r_freeToLSAForA);
    assign w_retAcked   = (w_ackSync == r_driveToLSA);
    assign w_misaligned = isMisaligned(r_size, r_isAtomic, r_addr[1:0]);

    // ----------------------------------------------------------------- FSM
    logic       w_capture;
    logic       w_chkFault;
    logic       w_retZero;
    logic       w_storeSetup;
    logic       w_readLatch;
    logic       w_takeResult;
    logic       w_freeToggle;
    logic       w_memReq;
    logic       w_memWe;
    logic [3:0] w_memBe;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= c_RESET_STATE;
        else       r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext  = r_state;
        w_capture    = 1'b0;
        w_chkFault   = 1'b0;
        w_retZero    = 1'b0;
        w_storeSetup = 1'b0;
        w_readLatch  = 1'b0;
        w_takeResult = 1'b0;
        w_freeToggle = 1'b0;
        w_memReq     = 1'b0;
        w_memWe      = 1'b0;
        w_memBe      = c_RESET_BE;

        case (r_state)
            ST_IDLE: begin
                if (w_reqPending) begin
                    w_capture   = 1'b1;
                    w_stateNext = ST_CHK;
                end
            end
            ST_CHK: begin
                if (w_misaligned) begin
                    w_chkFault = 1'b1;
                    if (r_isStore) begin
                        w_stateNext = ST_DONE;
                    end else begin
                        w_retZero   = 1'b1;
                        w_stateNext = ST_RET;
                    end
                end else if (r_isStore) begin
                    w_storeSetup = 1'b1;
                    w_stateNext  = ST_WREQ;
                end else begin
                    w_stateNext = ST_RREQ;
                end
            end
            ST_RREQ: begin
                w_memReq = 1'b1;
                w_memBe  = c_BE_ALL;
                if (i_mem_ready) w_stateNext = ST_RDATA;
            end
            ST_RDATA: begin
                w_readLatch = 1'b1;
                w_stateNext = ST_RET;
            end
            ST_RET: begin
                if (w_retAcked) begin
                    // A trapped atomic never read memory, so it has no
                    // write-back phase.
                    w_stateNext = (r_isAtomic && !r_faulted) ? ST_AWAIT : ST_DONE;
                end
            end
            ST_AWAIT: begin
                if (w_resPending) begin
                    w_takeResult = 1'b1;
                    w_stateNext  = ST_WREQ;
                end
            end
            ST_WREQ: begin
                w_memReq = 1'b1;
                w_memWe  = 1'b1;
                w_memBe  = r_be;
                if (i_mem_ready) w_stateNext = ST_DONE;
            end
            ST_DONE: begin
                w_freeToggle = 1'b1;
                w_stateNext  = ST_IDLE;
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr          <= c_RESET_WORD;
            r_index         <= '0;
            r_isStore       <= 1'b0;
            r_isAtomic      <= 1'b0;
            r_isUnsigned    <= 1'b0;
            r_size          <= SZ_B;
            r_storedata     <= c_RESET_WORD;
            r_areg          <= '0;
            r_faulted       <= 1'b0;
            r_be            <= c_RESET_BE;
            r_wdata         <= c_RESET_WORD;
            r_oprand        <= c_RESET_WORD;
            r_indexRet      <= '0;
            r_aregRet       <= '0;
            r_freeToLSA     <= 1'b0;
            r_driveToLSA    <= 1'b0;
            r_freeToLSAForA <= 1'b0;
            r_errMisalign   <= 1'b0;
        end else begin
            r_errMisalign <= w_chkFault;

            if (w_capture) begin
                r_addr       <= i_addr;
                r_index      <= i_index;
                // An atomic takes precedence over the store bit.
                r_isStore    <= i_type[c_TYPE_STORE] & ~i_type[c_TYPE_ATOMIC];
                r_isAtomic   <= i_type[c_TYPE_ATOMIC];
                r_isUnsigned <= i_type[c_TYPE_UNSIGNED];
                r_size       <= i_type[1:0];
                r_storedata  <= i_storedata;
                r_areg       <= i_areg;
                r_faulted    <= 1'b0;
            end

            if (w_chkFault) r_faulted <= 1'b1;

            if (w_retZero) begin
                r_oprand     <= c_RESET_WORD;
                r_indexRet   <= r_index;
                r_aregRet    <= r_areg;
                r_driveToLSA <= ~r_driveToLSA;
            end

            if (w_storeSetup) begin
                r_be    <= storeBe(r_size, r_addr[1:0]);
                r_wdata <= storeLanes(r_size, r_storedata);
            end

            if (w_readLatch) begin
                r_oprand     <= r_isAtomic ? i_mem_rdata
                                           : loadExtract(i_mem_rdata, r_addr[1:0],
                                                         r_size, r_isUnsigned);
                r_indexRet   <= r_index;
                r_aregRet    <= r_areg;
                r_driveToLSA <= ~r_driveToLSA;
            end

            if (w_takeResult) begin
                r_wdata         <= i_resultFromLSA;
                r_be            <= c_BE_ALL;
                r_freeToLSAForA <= ~r_freeToLSAForA;
            end

            if (w_freeToggle) r_freeToLSA <= ~r_freeToLSA;
        end
    end

    // ------------------------------------------------------------- outputs
    assign o_freeToLSA     = r_freeToLSA;
    assign o_driveToLSA    = r_driveToLSA;
    assign o_freeToLSAForA = r_freeToLSAForA;
    assign o_oprandToLSA   = r_oprand;
    assign o_indexToLSA    = r_indexRet;
    assign o_aregToLSA     = r_aregRet;
    assign o_mem_req       = w_memReq;
    assign o_mem_we        = w_memWe;
    assign o_mem_be        = w_memBe;
    assign o_mem_addr      = r_addr[MEM_AW+1:2];
    assign o_mem_wdata     = r_wdata;
    assign o_err_misalign  = r_errMisalign;

endmodule
`default_nettype wire
